// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the sequence-FSM test sequencer: controller state
// encoding, default pattern width and counter width derivation.
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_N = 16;

  // Bit-index counter width for an n-bit pattern.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Stimulus/response shift pair: parallel-load stimulus register shifted out
// LSB-first, and a response register shifted in from the MSB end so that the
// first captured bit lands in bit 0 after N shifts. Load clears the response.
module seq_shift_reg #(
  parameter int unsigned N = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [N-1:0] pattern_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic         sout_o,
  output logic [N-1:0] resp_o
);

  logic [N-1:0] stim_q, stim_d;
  logic [N-1:0] resp_q, resp_d;

  // Next-value selection: load takes priority over shift.
  always_comb begin
    stim_d = stim_q;
    resp_d = resp_q;
    if (load_i) begin
      stim_d = pattern_i;
      resp_d = '0;
    end else if (shift_i) begin
      stim_d = {1'b0, stim_q[N-1:1]};
      resp_d = {sin_i, resp_q[N-1:1]};
    end
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stim_q <= '0;
      resp_q <= '0;
    end else begin
      stim_q <= stim_d;
      resp_q <= resp_d;
    end
  end

  assign sout_o = stim_q[0];
  assign resp_o = resp_q;

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Sequencer for the five-state Mealy sequence FSM: on start it resets the
// target FSM for one cycle, drives the latched pattern into x LSB-first and
// captures y each cycle into the response word, then pulses done.
// Optional golden compare enabled by defining FSM_SEQ_CHECK_EN.
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] pattern,
  output logic         fsm_rst,
  output logic         fsm_x,
  input  logic         fsm_y,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] response
`ifdef FSM_SEQ_CHECK_EN
  ,
  input  logic [N-1:0] expected,
  output logic         mismatch
`endif
);

  localparam int unsigned CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_e           state_q;
  logic [CNT_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic             fsm_rst_q;
  logic             accept;
  logic             last_bit;
  logic             stim_bit;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (idx_q == LAST);

  seq_shift_reg #(
    .N(N)
  ) u_shift (
    .clk_i    (clk),
    .rst_ni   (reset),
    .load_i   (accept),
    .pattern_i(pattern),
    .shift_i  (state_q == RUN),
    .sin_i    (fsm_y),
    .sout_o   (stim_bit),
    .resp_o   (response)
  );

  // Controller FSM with bit counter and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fsm_rst_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RST;
            busy_q    <= 1'b1;
            fsm_rst_q <= 1'b1;
          end
        end
        RST: begin
          state_q   <= RUN;
          fsm_rst_q <= 1'b0;
          idx_q     <= '0;
        end
        RUN: begin
          if (idx_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fsm_rst = fsm_rst_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign fsm_x   = (state_q == RUN) && stim_bit;

`ifdef FSM_SEQ_CHECK_EN
  logic [N-1:0] expected_q;
  logic         mismatch_q;

  // Golden word latched with the pattern; the compare uses the response
  // value including the bit being captured on the final RUN edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected_q <= '0;
      mismatch_q <= 1'b0;
    end else if (accept) begin
      expected_q <= expected;
      mismatch_q <= 1'b0;
    end else if (last_bit) begin
      mismatch_q <= ({fsm_y, response[N-1:1]} != expected_q);
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_last;
  assign unused_last = last_bit;
`endif

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Testbench for fsm_seq_ctrl (N=8) driving a behavioural five-state Mealy
// target FSM. Scoreboard of expected responses checked by a negedge monitor.
// Define FSM_SEQ_CHECK_EN to also exercise the golden compare.
module tb_fsm_seq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] pattern;
  logic         fsm_rst;
  logic         fsm_x;
  logic         fsm_y;
  logic         busy;
  logic         done;
  logic [N-1:0] response;
  logic [N-1:0] expected;
`ifdef FSM_SEQ_CHECK_EN
  logic         mismatch;
`endif

  always #10 clk = ~clk;

  fsm_seq_ctrl #(.N(N)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .start   (start),
    .pattern (pattern),
    .fsm_rst (fsm_rst),
    .fsm_x   (fsm_x),
    .fsm_y   (fsm_y),
    .busy    (busy),
    .done    (done),
    .response(response)
`ifdef FSM_SEQ_CHECK_EN
    ,
    .expected(expected),
    .mismatch(mismatch)
`endif
  );

  // Target FSM tables, states A..E = 0..4, indexed [state][x].
  int NX [5][2] = '{'{1, 4}, '{1, 4}, '{3, 0}, '{0, 2}, '{2, 3}};
  int YT [5][2] = '{'{0, 1}, '{0, 1}, '{0, 1}, '{1, 1}, '{1, 0}};

  int tst = 1;
  always @(posedge clk) begin
    if (fsm_rst) tst <= 1;
    else         tst <= NX[tst][fsm_x];
  end
  assign fsm_y = (YT[tst][fsm_x] != 0);

  // Reference: walk the target FSM from B over the pattern bits.
  function automatic logic [N-1:0] ref_resp(input logic [N-1:0] p);
    logic [N-1:0] r;
    int s;
    r = '0;
    s = 1;
    for (int i = 0; i < N; i++) begin
      r[i] = (YT[s][p[i]] != 0);
      s = NX[s][p[i]];
    end
    return r;
  endfunction

  typedef struct {
    logic [N-1:0] resp;
    int           cyc;
    logic         mm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rst_cnt = 0;
  logic prev_done = 1'b0;
  logic last_mm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Monitor: consumes one scoreboard entry per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      rst_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if (fsm_rst) begin
        rst_cnt++;
        chk("x_low_in_rst", int'(fsm_x), 0);
      end
      if (!busy) chk("x_low_idle", int'(fsm_x), 0);
      if (done) begin
        chk("done_single_pulse", int'(prev_done), 0);
        chk("busy_at_done", int'(busy), 1);
        if (sb.size() == 0) begin
          chk("unexpected_done", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("response", int'(response), int'(e.resp));
          chk("done_cycle", cyc + 1, e.cyc);
          chk("fsm_rst_cycles", rst_cnt, 1);
`ifdef FSM_SEQ_CHECK_EN
          chk("mismatch", int'(mismatch), int'(e.mm));
`endif
          last_mm = e.mm;
        end
        rst_cnt = 0;
      end
      prev_done = done;
    end
  end

  // Wait for IDLE, request a run, and record the expectation at acceptance.
  task automatic start_run(input logic [N-1:0] pat, input logic [N-1:0] expw,
                           input bit hold, input bit chg);
    exp_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    chk("idle_wait", int'(busy), 0);
`ifdef FSM_SEQ_CHECK_EN
    chk("mismatch_held", int'(mismatch), int'(last_mm));
`endif
    start    = 1'b1;
    pattern  = pat;
    expected = expw;
    @(posedge clk);
    #1;
    e.resp = ref_resp(pat);
    e.cyc  = cyc + N + 2;
    e.mm   = (e.resp != expw);
    sb.push_back(e);
    chk("resp_clear_on_start", int'(response), 0);
`ifdef FSM_SEQ_CHECK_EN
    chk("mismatch_clear_on_start", int'(mismatch), 0);
`endif
    if (!hold) start = 1'b0;
    pattern  = chg ? ~pat : N'($urandom);
    expected = N'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < N + 10) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done), 1);
    start = 1'b0;
  endtask

  task automatic run_one(input logic [N-1:0] pat, input logic [N-1:0] expw,
                         input bit hold, input bit chg);
    start_run(pat, expw, hold, chg);
    wait_done();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] p;
    logic [N-1:0] ew;
    rst_n    = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    expected = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fsm_rst", int'(fsm_rst), 0);
    chk("rst_fsm_x", int'(fsm_x), 0);
    chk("rst_response", int'(response), 0);
`ifdef FSM_SEQ_CHECK_EN
    chk("rst_mismatch", int'(mismatch), 0);
`endif
    rst_n = 1'b1;

    run_one(8'h00, 8'h00, 1'b0, 1'b0);
    run_one(8'hFF, 8'hDD, 1'b0, 1'b0);
    run_one(8'hFF, 8'hDC, 1'b1, 1'b0);
    run_one(8'hFF, 8'hDD, 1'b0, 1'b1);

    // Abort during RUN bit 4.
    start_run(8'hFF, 8'hDD, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #5;
    chk("busy_mid_run", int'(busy), 1);
    chk("x_bit4", int'(fsm_x), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_fsm_x", int'(fsm_x), 0);
    chk("abort_fsm_rst", int'(fsm_rst), 0);
    chk("abort_response", int'(response), 0);
    sb.delete();
    last_mm = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_one(8'hFF, 8'hDD, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      p  = N'($urandom);
      ew = ref_resp(p);
      if ($urandom_range(0, 1) == 1) ew[$urandom_range(0, N - 1)] ^= 1'b1;
      run_one(p, ew, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("stray_fsm_rst", rst_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
